except_merge_stage: RTL and testbench

EXCEPT_MERGE_STAGE -- requirements
Module: except_merge_stage

---
 rtl/except_merge_stage.sv | 113 +++++++++++
 tb/tb_except_merge_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/except_merge_stage.sv
// Merges upstream and local exceptions into a registered trap record (1-cycle latency).
// Backpressure: stall holds the record; flush clears it and releases the PENDING trap.
module except_merge_stage #(
  parameter int XLEN  = 64,
  parameter int NSRC  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 valid_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic                 up_exc_i,
  input  logic [XLEN-1:0]      up_epc_i,
  input  logic [XLEN-1:0]      up_ecause_i,
  input  logic [XLEN-1:0]      up_etval_i,
  input  logic [NSRC-1:0]      src_exc_i,
  input  logic [NSRC*XLEN-1:0] src_ecause_i,
  input  logic [NSRC*XLEN-1:0] src_etval_i,
  output logic                 exc_o,
  output logic [XLEN-1:0]      epc_o,
  output logic [XLEN-1:0]      ecause_o,
  output logic [XLEN-1:0]      etval_o,
  output logic                 except_happen_o,
  output logic                 trap_pending_o,
  output logic [CNT_W-1:0]     exc_cnt_o
);

  typedef enum logic {RUN, PENDING} state_t;

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
  } exc_t;

  state_t           state_q, state_d;
  exc_t             loc_exc, merged, exc_q;
  logic [CNT_W-1:0] exc_cnt_q;

  // Descending scan so the lowest-index active source wins; PENDING masks all sources.
  always_comb begin
    loc_exc = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (src_exc_i[k] && valid_i && (state_q == RUN)) begin
        loc_exc.vld   = 1'b1;
        loc_exc.epc   = pc_i;
        loc_exc.cause = src_ecause_i[k*XLEN +: XLEN];
        loc_exc.tval  = src_etval_i[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    merged = '0;
    if (up_exc_i) begin
      merged.vld   = 1'b1;
      merged.epc   = up_epc_i;
      merged.cause = up_ecause_i;
      merged.tval  = up_etval_i;
    end else if (loc_exc.vld) begin
      merged = loc_exc;
    end
  end

  assign except_happen_o = rst && !up_exc_i && loc_exc.vld && !stall && !flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (merged.vld && !stall && !flush) state_d = PENDING;
      PENDING: if (flush) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A no-exception load writes all-zero fields so stale cause/tval never leak out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_q <= '0;
    end else if (flush) begin
      exc_q <= '0;
    end else if (!stall) begin
      exc_q <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_cnt_q <= '0;
    end else if (except_happen_o && (exc_cnt_q != {CNT_W{1'b1}})) begin
      exc_cnt_q <= exc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign exc_o          = exc_q.vld;
  assign epc_o          = exc_q.epc;
  assign ecause_o       = exc_q.cause;
  assign etval_o        = exc_q.tval;
  assign trap_pending_o = (state_q == PENDING);
  assign exc_cnt_o      = exc_cnt_q;

endmodule

// File: tb/tb_except_merge_stage.sv
// Directed plus random stimulus against a behavioural model; expected records queued per step.
module tb_except_merge_stage;

  localparam int XLEN  = 64;
  localparam int NSRC  = 3;
  localparam int CNT_W = 2;

  typedef struct {
    logic            exc;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            tp;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic stall, flush, valid_i, up_exc_i;
  logic [XLEN-1:0] pc_i, up_epc_i, up_ecause_i, up_etval_i;
  logic [NSRC-1:0] src_exc_i;
  logic [NSRC*XLEN-1:0] src_ecause_i, src_etval_i;
  logic exc_o, except_happen_o, trap_pending_o;
  logic [XLEN-1:0] epc_o, ecause_o, etval_o;
  logic [CNT_W-1:0] exc_cnt_o;

  except_merge_stage #(.XLEN(XLEN), .NSRC(NSRC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_i(valid_i), .pc_i(pc_i),
    .up_exc_i(up_exc_i), .up_epc_i(up_epc_i), .up_ecause_i(up_ecause_i), .up_etval_i(up_etval_i),
    .src_exc_i(src_exc_i), .src_ecause_i(src_ecause_i), .src_etval_i(src_etval_i),
    .exc_o(exc_o), .epc_o(epc_o), .ecause_o(ecause_o), .etval_o(etval_o),
    .except_happen_o(except_happen_o), .trap_pending_o(trap_pending_o), .exc_cnt_o(exc_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  exp_t sb_q[$];

  // Reference state
  logic            m_pend;
  logic            m_exc;
  logic [XLEN-1:0] m_epc, m_cause, m_tval;
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_exc = 1'b0; m_epc = '0; m_cause = '0; m_tval = '0; m_cnt = '0;
  endtask

  task automatic set_src(input logic [NSRC-1:0] flags, input logic [XLEN-1:0] c0,
                         input logic [XLEN-1:0] c1, input logic [XLEN-1:0] c2);
    src_exc_i    = flags;
    src_ecause_i = {c2, c1, c0};
    src_etval_i  = {c2 ^ 64'hA0, c1 ^ 64'hA0, c0 ^ 64'hA0};
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; valid_i = 0; pc_i = '0; up_exc_i = 0;
    up_epc_i = '0; up_ecause_i = '0; up_etval_i = '0;
    set_src('0, '0, '0, '0);
  endtask

  // One clock: predict, check combinational flag, push expectation, clock, pop and compare.
  task automatic step(input string tag);
    logic            l_vld, mv, happen;
    logic [XLEN-1:0] l_cause, l_tval, mepc, mc, mt;
    exp_t e, got;
    #1;
    l_vld = 0; l_cause = '0; l_tval = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (!l_vld && src_exc_i[k] && valid_i && !m_pend) begin
        l_vld = 1; l_cause = src_ecause_i[k*XLEN +: XLEN]; l_tval = src_etval_i[k*XLEN +: XLEN];
      end
    end
    if (up_exc_i) begin
      mv = 1; mepc = up_epc_i; mc = up_ecause_i; mt = up_etval_i;
    end else if (l_vld) begin
      mv = 1; mepc = pc_i; mc = l_cause; mt = l_tval;
    end else begin
      mv = 0; mepc = '0; mc = '0; mt = '0;
    end
    happen = !m_pend && !up_exc_i && l_vld && !stall && !flush;
    chk({tag, ".happen"}, XLEN'(except_happen_o), XLEN'(happen));
    if (flush) begin
      m_exc = 0; m_epc = '0; m_cause = '0; m_tval = '0;
    end else if (!stall) begin
      m_exc = mv; m_epc = mepc; m_cause = mc; m_tval = mt;
    end
    if (!m_pend) begin
      if (mv && !stall && !flush) m_pend = 1;
    end else if (flush) begin
      m_pend = 0;
    end
    if (happen && m_cnt != 2'b11) m_cnt = m_cnt + 2'd1;
    e.exc = m_exc; e.epc = m_epc; e.cause = m_cause; e.tval = m_tval; e.tp = m_pend; e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk({tag, ".exc"}, XLEN'(exc_o), XLEN'(got.exc));
    chk({tag, ".epc"}, epc_o, got.epc);
    chk({tag, ".cause"}, ecause_o, got.cause);
    chk({tag, ".tval"}, etval_o, got.tval);
    chk({tag, ".pend"}, XLEN'(trap_pending_o), XLEN'(got.tp));
    chk({tag, ".cnt"}, XLEN'(exc_cnt_o), XLEN'(got.cnt));
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 0;
    #3;
    chk("rst.exc", XLEN'(exc_o), 0);
    chk("rst.cause", ecause_o, 0);
    chk("rst.pend", XLEN'(trap_pending_o), 0);
    chk("rst.cnt", XLEN'(exc_cnt_o), 0);
    chk("rst.happen", XLEN'(except_happen_o), 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    step("idle");

    // Lowest active index (1) wins among sources 1 and 2
    valid_i = 1; pc_i = 64'h1000;
    set_src(3'b110, 64'd2, 64'd5, 64'd7);
    step("prio");
    chk("prio.cause_c", ecause_o, 64'd5);
    chk("prio.epc_c", epc_o, 64'h1000);
    chk("prio.cnt_c", XLEN'(exc_cnt_o), 1);
    chk("prio.pend_c", XLEN'(trap_pending_o), 1);

    set_src(3'b001, 64'd2, 64'd0, 64'd0);
    for (int i = 0; i < 3; i++) step("pend_sup");
    chk("pend_sup.exc_c", XLEN'(exc_o), 0);
    chk("pend_sup.cnt_c", XLEN'(exc_cnt_o), 1);
    flush = 1; step("pend_flush"); flush = 0;
    chk("pend_flush.pend_c", XLEN'(trap_pending_o), 0);

    up_exc_i = 1; up_epc_i = 64'h2000; up_ecause_i = 64'hD; up_etval_i = 64'h99;
    step("upwin");
    chk("upwin.cause_c", ecause_o, 64'hD);
    chk("upwin.epc_c", epc_o, 64'h2000);
    chk("upwin.cnt_c", XLEN'(exc_cnt_o), 1);
    up_exc_i = 0;
    flush = 1; step("upwin_flush"); flush = 0;

    pc_i = 64'h3000; set_src(3'b100, 64'd0, 64'd0, 64'd9);
    step("load");
    stall = 1; set_src(3'b000, 64'd0, 64'd0, 64'd0);
    step("stall1"); step("stall2");
    chk("stall.cause_c", ecause_o, 64'd9);
    flush = 1; step("stall_flush");
    chk("stall_flush.exc_c", XLEN'(exc_o), 0);
    stall = 0;

    // Flush coinciding with a local exception drops it
    set_src(3'b001, 64'd4, 64'd0, 64'd0);
    step("flush_drop");
    chk("flush_drop.cnt_c", XLEN'(exc_cnt_o), 2);
    flush = 0;

    for (int i = 0; i < 3; i++) begin
      set_src(3'b010, 64'd0, 64'd3 + 64'(i), 64'd0);
      step("sat_exc");
      chk("sat.cnt_c", XLEN'(exc_cnt_o), 3);
      set_src(3'b000, 64'd0, 64'd0, 64'd0);
      flush = 1; step("sat_flush"); flush = 0;
    end

    // Asynchronous reset while PENDING
    set_src(3'b001, 64'd6, 64'd0, 64'd0);
    step("pre_arst");
    chk("pre_arst.pend_c", XLEN'(trap_pending_o), 1);
    #2 rst = 0;
    #1;
    chk("arst.exc", XLEN'(exc_o), 0);
    chk("arst.cause", ecause_o, 0);
    chk("arst.pend", XLEN'(trap_pending_o), 0);
    chk("arst.cnt", XLEN'(exc_cnt_o), 0);
    chk("arst.happen", XLEN'(except_happen_o), 0);
    @(posedge clk);
    #1 rst = 1;
    model_reset();
    step("post_arst");
    chk("post_arst.cnt_c", XLEN'(exc_cnt_o), 1);
    flush = 1; step("post_arst_flush"); flush = 0;

    for (int i = 0; i < 60; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 4) == 0);
      valid_i = ($urandom_range(0, 3) != 0);
      pc_i = {$urandom, $urandom};
      up_exc_i = ($urandom_range(0, 5) == 0);
      up_epc_i = {$urandom, $urandom};
      up_ecause_i = 64'($urandom_range(0, 31));
      up_etval_i = {$urandom, $urandom};
      set_src(3'($urandom_range(0, 7)), 64'($urandom_range(0, 15)),
              64'($urandom_range(16, 31)), 64'($urandom_range(32, 47)));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
